// File: rtl/multicycle_control_if.sv
// Control-side bundle between the multicycle sequencer and the IR/ALU/regfile datapath.
// Latency: none, wires only.
// Backpressure: Stall and InstrReady flow toward the sequencer; strobes flow out.
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic             Stall;
    logic             InstrReady;
    logic [5:0]       OpCode;
    logic [5:0]       Func;
    logic             InstrReq;
    logic             IRWrite;
    logic [2:0]       ALUOp;
    logic             RegWrite;
    logic             PCWrite;
    logic [1:0]       TrapCause;
    logic [CNT_W-1:0] RetireCount;
    logic [2:0]       State;

    // Sequencer side: consumes memory/IR status, drives strobes and status.
    modport master (
        input  Stall, InstrReady, OpCode, Func,
        output InstrReq, IRWrite, ALUOp, RegWrite, PCWrite, TrapCause, RetireCount, State
    );

    // Datapath / environment side.
    modport slave (
        output Stall, InstrReady, OpCode, Func,
        input  InstrReq, IRWrite, ALUOp, RegWrite, PCWrite, TrapCause, RetireCount, State
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle R-type sequencer: IDLE -> FETCH -> DECODE -> (EXECUTE) -> WRITEBACK, traps on illegal/timeout.
// Latency: 4 cycles from the InstrReady cycle to the next InstrReq for ALU ops, 3 for NOP.
// Backpressure: Stall freezes all state and masks every strobe; FETCH waits on InstrReady up to TIMEOUT cycles.
module multicycle_control #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                 Clk,
    input  logic                 Reset,
    multicycle_control_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    // Last FETCH cycle that may still be acked before the timeout trap fires.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t           state_q,  state_d;
    logic [2:0]       aluop_q,  aluop_d;
    logic [1:0]       trap_q,   trap_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [7:0]       tmo_q,    tmo_d;
    logic             nop_q,    nop_d;

    logic             dec_legal;
    logic             dec_nop;
    logic [2:0]       dec_alu;

    // Classify the IR fields; anything other than the listed R-type functs is illegal.
    always_comb begin
        dec_legal = 1'b1;
        dec_nop   = 1'b0;
        dec_alu   = 3'b000;
        case (bus.Func)
            6'd36:   dec_alu = 3'b000;
            6'd37:   dec_alu = 3'b001;
            6'd32:   dec_alu = 3'b010;
            6'd34:   dec_alu = 3'b110;
            6'd42:   dec_alu = 3'b111;
            6'd0:    dec_nop = 1'b1;
            default: dec_legal = 1'b0;
        endcase
        if (bus.OpCode != 6'd0) begin
            dec_legal = 1'b0;
        end
    end

    // Next-state logic; Stall leaves every register at its current value.
    always_comb begin
        state_d  = state_q;
        aluop_d  = aluop_q;
        trap_d   = trap_q;
        retire_d = retire_q;
        tmo_d    = tmo_q;
        nop_d    = nop_q;
        if (!bus.Stall) begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH;
                    tmo_d   = '0;
                end
                S_FETCH: begin
                    if (bus.InstrReady) begin
                        // An ack in the final allowed cycle still beats the timeout.
                        state_d = S_DECODE;
                        tmo_d   = '0;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = S_TRAP;
                        trap_d  = TRAP_TIMEOUT;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (!dec_legal) begin
                        state_d = S_TRAP;
                        trap_d  = TRAP_ILLEGAL;
                    end else if (dec_nop) begin
                        // NOP skips EXECUTE and keeps the previous ALU operation.
                        state_d = S_WRITEBACK;
                        nop_d   = 1'b1;
                    end else begin
                        state_d = S_EXECUTE;
                        aluop_d = dec_alu;
                        nop_d   = 1'b0;
                    end
                end
                S_EXECUTE: begin
                    state_d = S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    retire_d = retire_q + 1'b1;
                    state_d  = S_FETCH;
                    tmo_d    = '0;
                end
                S_TRAP: begin
                    state_d = S_TRAP;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Sequencer registers; reset aborts any instruction in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            aluop_q  <= 3'b000;
            trap_q   <= TRAP_NONE;
            retire_q <= '0;
            tmo_q    <= '0;
            nop_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            aluop_q  <= aluop_d;
            trap_q   <= trap_d;
            retire_q <= retire_d;
            tmo_q    <= tmo_d;
            nop_q    <= nop_d;
        end
    end

    // Strobes decode from the registered state so reset drops them immediately.
    assign bus.InstrReq    = (state_q == S_FETCH) && !bus.Stall;
    assign bus.IRWrite     = (state_q == S_FETCH) && bus.InstrReady && !bus.Stall;
    assign bus.RegWrite    = (state_q == S_WRITEBACK) && !nop_q && !bus.Stall;
    assign bus.PCWrite     = (state_q == S_WRITEBACK) && !bus.Stall;
    assign bus.ALUOp       = aluop_q;
    assign bus.TrapCause   = trap_q;
    assign bus.RetireCount = retire_q;
    assign bus.State       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a per-cycle expectation queue and a decoupled monitor.
// Runs with CNT_W=2 and TIMEOUT=4 so counter wrap and the fetch timeout are reachable quickly.
module tb_multicycle_control;

    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 4;

    localparam logic [2:0] S_I = 3'd0;
    localparam logic [2:0] S_F = 3'd1;
    localparam logic [2:0] S_D = 3'd2;
    localparam logic [2:0] S_E = 3'd3;
    localparam logic [2:0] S_W = 3'd4;
    localparam logic [2:0] S_T = 3'd5;

    typedef struct packed {
        logic [2:0]       st;
        logic             req;
        logic             irw;
        logic             rw;
        logic             pcw;
        logic [2:0]       alu;
        logic [1:0]       tc;
        logic [CNT_W-1:0] rc;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   ncyc;
    exp_t exp_q[$];

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the edge and queue what that cycle must show.
    task automatic cyc(input logic r, input logic s, input logic rdy,
                       input logic [5:0] op, input logic [5:0] fn,
                       input logic [2:0] st, input logic req, input logic irw,
                       input logic rw, input logic pcw, input logic [2:0] alu,
                       input logic [1:0] tc, input logic [CNT_W-1:0] rc);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = r;
        bus.Stall      = s;
        bus.InstrReady = rdy;
        bus.OpCode     = op;
        bus.Func       = fn;
        e.st  = st;  e.req = req; e.irw = irw; e.rw = rw; e.pcw = pcw;
        e.alu = alu; e.tc  = tc;  e.rc  = rc;
        exp_q.push_back(e);
    endtask

    // Monitor: every mid-cycle sample with a pending expectation is compared.
    initial begin
        exp_t e;
        exp_t g;
        ncyc = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g.st  = bus.State;    g.req = bus.InstrReq; g.irw = bus.IRWrite;
                g.rw  = bus.RegWrite; g.pcw = bus.PCWrite;  g.alu = bus.ALUOp;
                g.tc  = bus.TrapCause; g.rc = bus.RetireCount;
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL cycle%0d got st=%0d req=%b irw=%b rw=%b pcw=%b alu=%b tc=%b rc=%0d exp st=%0d req=%b irw=%b rw=%b pcw=%b alu=%b tc=%b rc=%0d",
                             ncyc, g.st, g.req, g.irw, g.rw, g.pcw, g.alu, g.tc, g.rc,
                             e.st, e.req, e.irw, e.rw, e.pcw, e.alu, e.tc, e.rc);
                end
                ncyc++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.Stall = 1'b0; bus.InstrReady = 1'b0; bus.OpCode = 6'd0; bus.Func = 6'd0;

        // Reset state, including InstrReady high during reset.
        cyc(1,0,0, 0, 0,  S_I,0,0,0,0, 3'b000,2'b00,0);
        cyc(1,0,1, 0, 0,  S_I,0,0,0,0, 3'b000,2'b00,0);
        cyc(0,0,0, 0, 0,  S_I,0,0,0,0, 3'b000,2'b00,0);

        // ADD acked immediately: 1,2,3,4 then FETCH.
        cyc(0,0,1, 0,32,  S_F,1,1,0,0, 3'b000,2'b00,0);
        cyc(0,0,0, 0,32,  S_D,0,0,0,0, 3'b000,2'b00,0);
        cyc(0,0,0, 0,32,  S_E,0,0,0,0, 3'b010,2'b00,0);
        cyc(0,0,0, 0,32,  S_W,0,0,1,1, 3'b010,2'b00,0);

        // Back-to-back AND, OR, SUB, SLT (RetireCount wraps 3->0 at width 2).
        cyc(0,0,1, 0,36,  S_F,1,1,0,0, 3'b010,2'b00,1);
        cyc(0,0,0, 0,36,  S_D,0,0,0,0, 3'b010,2'b00,1);
        cyc(0,0,0, 0,36,  S_E,0,0,0,0, 3'b000,2'b00,1);
        cyc(0,0,0, 0,36,  S_W,0,0,1,1, 3'b000,2'b00,1);
        cyc(0,0,1, 0,37,  S_F,1,1,0,0, 3'b000,2'b00,2);
        cyc(0,0,0, 0,37,  S_D,0,0,0,0, 3'b000,2'b00,2);
        cyc(0,0,0, 0,37,  S_E,0,0,0,0, 3'b001,2'b00,2);
        cyc(0,0,0, 0,37,  S_W,0,0,1,1, 3'b001,2'b00,2);
        cyc(0,0,1, 0,34,  S_F,1,1,0,0, 3'b001,2'b00,3);
        cyc(0,0,0, 0,34,  S_D,0,0,0,0, 3'b001,2'b00,3);
        cyc(0,0,0, 0,34,  S_E,0,0,0,0, 3'b110,2'b00,3);
        cyc(0,0,0, 0,34,  S_W,0,0,1,1, 3'b110,2'b00,3);
        cyc(0,0,1, 0,42,  S_F,1,1,0,0, 3'b110,2'b00,0);
        cyc(0,0,0, 0,42,  S_D,0,0,0,0, 3'b110,2'b00,0);
        cyc(0,0,0, 0,42,  S_E,0,0,0,0, 3'b111,2'b00,0);
        cyc(0,0,0, 0,42,  S_W,0,0,1,1, 3'b111,2'b00,0);

        // NOP: DECODE straight to WRITEBACK, no RegWrite, ALUOp held; then OR.
        cyc(0,0,1, 0, 0,  S_F,1,1,0,0, 3'b111,2'b00,1);
        cyc(0,0,0, 0, 0,  S_D,0,0,0,0, 3'b111,2'b00,1);
        cyc(0,0,0, 0, 0,  S_W,0,0,0,1, 3'b111,2'b00,1);
        cyc(0,0,1, 0,37,  S_F,1,1,0,0, 3'b111,2'b00,2);
        cyc(0,0,0, 0,37,  S_D,0,0,0,0, 3'b111,2'b00,2);
        cyc(0,0,0, 0,37,  S_E,0,0,0,0, 3'b001,2'b00,2);
        cyc(0,0,0, 0,37,  S_W,0,0,1,1, 3'b001,2'b00,2);

        // Stall in FETCH masks IRWrite; stall 3 cycles in EXECUTE; reset in WRITEBACK.
        cyc(0,1,1, 0,32,  S_F,0,0,0,0, 3'b001,2'b00,3);
        cyc(0,0,1, 0,32,  S_F,1,1,0,0, 3'b001,2'b00,3);
        cyc(0,0,0, 0,32,  S_D,0,0,0,0, 3'b001,2'b00,3);
        cyc(0,1,0, 0,32,  S_E,0,0,0,0, 3'b010,2'b00,3);
        cyc(0,1,0, 0,32,  S_E,0,0,0,0, 3'b010,2'b00,3);
        cyc(0,1,0, 0,32,  S_E,0,0,0,0, 3'b010,2'b00,3);
        cyc(0,0,0, 0,32,  S_E,0,0,0,0, 3'b010,2'b00,3);
        cyc(1,0,0, 0,32,  S_I,0,0,0,0, 3'b000,2'b00,0);
        cyc(0,0,0, 0, 0,  S_I,0,0,0,0, 3'b000,2'b00,0);

        // Seven NOPs: reach 3, then four more retirements wrap back to 3.
        for (int i = 0; i < 7; i++) begin
            cyc(0,0,1, 0,0, S_F,1,1,0,0, 3'b000,2'b00,CNT_W'(i % 4));
            cyc(0,0,0, 0,0, S_D,0,0,0,0, 3'b000,2'b00,CNT_W'(i % 4));
            if (i == 2) begin
                cyc(0,1,0, 0,0, S_W,0,0,0,0, 3'b000,2'b00,CNT_W'(i % 4));
            end
            cyc(0,0,0, 0,0, S_W,0,0,0,1, 3'b000,2'b00,CNT_W'(i % 4));
        end

        // Illegal OpCode traps, TRAP is absorbing, Reset clears the cause.
        cyc(0,0,1, 8,32,  S_F,1,1,0,0, 3'b000,2'b00,3);
        cyc(0,0,0, 8,32,  S_D,0,0,0,0, 3'b000,2'b00,3);
        cyc(0,0,1, 8,32,  S_T,0,0,0,0, 3'b000,2'b01,3);
        cyc(0,0,1, 0,32,  S_T,0,0,0,0, 3'b000,2'b01,3);
        cyc(0,0,1, 0,32,  S_T,0,0,0,0, 3'b000,2'b01,3);
        cyc(1,0,0, 0, 0,  S_I,0,0,0,0, 3'b000,2'b00,0);
        cyc(0,0,0, 0, 0,  S_I,0,0,0,0, 3'b000,2'b00,0);

        // Unlisted Func with OpCode=0 is also illegal.
        cyc(0,0,1, 0,33,  S_F,1,1,0,0, 3'b000,2'b00,0);
        cyc(0,0,0, 0,33,  S_D,0,0,0,0, 3'b000,2'b00,0);
        cyc(0,0,0, 0,33,  S_T,0,0,0,0, 3'b000,2'b01,0);
        cyc(1,0,0, 0, 0,  S_I,0,0,0,0, 3'b000,2'b00,0);
        cyc(0,0,0, 0, 0,  S_I,0,0,0,0, 3'b000,2'b00,0);

        // Fetch timeout: four unacked FETCH cycles, then TRAP with cause 10.
        cyc(0,0,0, 0,32,  S_F,1,0,0,0, 3'b000,2'b00,0);
        cyc(0,0,0, 0,32,  S_F,1,0,0,0, 3'b000,2'b00,0);
        cyc(0,0,0, 0,32,  S_F,1,0,0,0, 3'b000,2'b00,0);
        cyc(0,0,0, 0,32,  S_F,1,0,0,0, 3'b000,2'b00,0);
        cyc(0,0,1, 0,32,  S_T,0,0,0,0, 3'b000,2'b10,0);
        cyc(0,0,1, 0,32,  S_T,0,0,0,0, 3'b000,2'b10,0);
        cyc(1,0,0, 0, 0,  S_I,0,0,0,0, 3'b000,2'b00,0);
        cyc(0,0,0, 0, 0,  S_I,0,0,0,0, 3'b000,2'b00,0);

        // Ack on the fourth FETCH cycle wins over the timeout.
        cyc(0,0,0, 0,32,  S_F,1,0,0,0, 3'b000,2'b00,0);
        cyc(0,0,0, 0,32,  S_F,1,0,0,0, 3'b000,2'b00,0);
        cyc(0,0,0, 0,32,  S_F,1,0,0,0, 3'b000,2'b00,0);
        cyc(0,0,1, 0,32,  S_F,1,1,0,0, 3'b000,2'b00,0);
        cyc(0,0,0, 0,32,  S_D,0,0,0,0, 3'b000,2'b00,0);
        cyc(0,0,0, 0,32,  S_E,0,0,0,0, 3'b010,2'b00,0);

        // Let the monitor drain the last expectation.
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the R-type datapath: fetch → decode → execute → writeback, one instruction at a time.
- Handshakes with instruction memory, latches the decoded ALU operation and pulses the IR, register-file and PC write enables.
- Traps on illegal encodings or a fetch timeout.
- Sits between the instruction memory/IR and the ALU/register file and replaces the purely combinational decode path.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- TIMEOUT, 255, maximum FETCH wait cycles with InstrReady low before trapping (legal range 1..255).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Stall  input  1  freezes the FSM and suppresses all write pulses while high.
- InstrReady  input  1  instruction memory ack; IR data is valid this cycle.
- OpCode  input  6  IR[31:26], valid from DECODE onward.
- Func  input  6  IR[5:0], valid from DECODE onward.
- InstrReq  output  1  fetch request.
- IRWrite  output  1  IR load strobe.
- ALUOp  output  3  registered ALU operation.
- RegWrite  output  1  register-file write strobe.
- PCWrite  output  1  PC+4 update strobe.
- TrapCause  output  2  00 none, 01 illegal instruction, 10 fetch timeout; sticky.
- RetireCount  output  CNT_W  instructions retired, wraps modulo 2^CNT_W.
- State  output  3  IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, TRAP=5.

Behaviour:
- Reset (asynchronous):
  - State=IDLE, ALUOp=000, TrapCause=00, RetireCount=0, timeout counter=0.
  - All strobes and InstrReq are 0 because they decode from IDLE.
- Stall=1 holds State, timeout counter, ALUOp and RetireCount, and forces InstrReq/IRWrite/RegWrite/PCWrite to 0. Stall has priority over every transition except Reset.
- IDLE: go to FETCH next cycle unconditionally.
- FETCH:
  - InstrReq=1.
  - IRWrite = InstrReady (Mealy, same cycle).
  - InstrReady=1: go to DECODE and clear the timeout counter.
  - InstrReady=0: the counter increments. When the counter equals TIMEOUT-1 and InstrReady=0, go to TRAP with TrapCause=10.
  - InstrReady in the final allowed cycle wins over the timeout.
  - The counter clears on every FETCH entry.
- DECODE: classify OpCode/Func. OpCode≠0 or an unlisted Func is illegal.
  - Func=36 (AND): ALUOp←000, go to EXECUTE.
  - Func=37 (OR): ALUOp←001, go to EXECUTE.
  - Func=32 (ADD): ALUOp←010, go to EXECUTE.
  - Func=34 (SUB): ALUOp←110, go to EXECUTE.
  - Func=42 (SLT): ALUOp←111, go to EXECUTE.
  - OpCode=0, Func=0 (NOP): ALUOp unchanged, go directly to WRITEBACK with RegWrite suppressed.
  - Illegal: go to TRAP with TrapCause=01. ALUOp unchanged, PC not advanced.
- EXECUTE: one cycle. ALUOp is stable and the datapath captures the ALU result. Go to WRITEBACK.
- WRITEBACK:
  - PCWrite=1 for one cycle; RegWrite=1 only for non-NOP instructions.
  - RetireCount increments (NOP included), wrapping from 2^CNT_W-1 to 0.
  - Go to FETCH.
- TRAP: absorbing state. All strobes and InstrReq are 0; TrapCause holds. Exit only via Reset.
- ALUOp is registered: it changes only on the DECODE→EXECUTE transition and holds otherwise.
- Strobes are single-cycle; no strobe is asserted in IDLE, DECODE or TRAP.
- Latency: a legal ALU instruction takes 4 cycles from the InstrReady cycle to the next InstrReq (FETCH-ack, DECODE, EXECUTE, WRITEBACK). A NOP takes 3.
- Reset asserted mid-instruction aborts immediately: no partial RegWrite/PCWrite, and RetireCount clears.

Test Plan:
- Reset release, InstrReady=1 in the first FETCH cycle, OpCode=0/Func=32 → States 0,1,2,3,4,1. ALUOp=010 from the EXECUTE cycle. RegWrite=PCWrite=1 in the WRITEBACK cycle only. RetireCount=1.
- Back-to-back AND, OR, SUB, SLT, each acked immediately → ALUOp sequence 000,001,110,111. RetireCount=4 after 16 cycles of execution. One RegWrite pulse per instruction.
- OpCode=0/Func=0, then OpCode=0/Func=37 → NOP: DECODE→WRITEBACK with PCWrite=1, RegWrite=0, ALUOp held at its prior value. OR then proceeds normally. RetireCount=2.
- OpCode=8/Func=32 → TRAP, TrapCause=01, PCWrite never asserted, InstrReq=0 forever. Reset returns State=0, TrapCause=00.
- TIMEOUT=4, InstrReady held 0 → 4 FETCH cycles, then TRAP with TrapCause=10. Repeat with InstrReady=1 on the 4th FETCH cycle → DECODE, no trap.
- Stall=1 for 3 cycles in EXECUTE, then Reset pulsed while in WRITEBACK with CNT_W=2 and RetireCount=3 → State frozen and no strobes during the stall. Reset clears RetireCount to 0 immediately with no RegWrite. Separately, 4 retirements from 3 wrap RetireCount to 3.
